// File: rtl/riscv_defines.sv
`default_nettype none
// ============================================================================
// Package     : riscv_defines
// Description : Shared instruction, trap-request and fetch-packet types.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_defines;

    typedef logic [31:0] inst_t;

    localparam inst_t       NOP_INST                = 32'h0000_0013;
    localparam logic [31:0] CAUSE_INST_ACCESS_FAULT = 32'd1;

    typedef struct packed {
        logic        valid;
        logic [1:0]  mode;
        logic [31:0] cause;
        logic [31:0] pc;
        logic [31:0] tval;
    } trap_req_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pcplus4;
        inst_t       inst;
        trap_req_t   trap_req;
    } fetch_pkt_t;

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Circular packet FIFO between fetch and decode with redirect
//               flush and intake blocking behind a trapping packet.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import riscv_defines::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         start,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  pc_f,
    input  logic [31:0]                  pcplus4_f,
    input  inst_t                        inst_f,
    input  trap_req_t                    trap_req_f,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  pc_d,
    output logic [31:0]                  pcplus4_d,
    output inst_t                        inst_d,
    output trap_req_t                    trap_req_d,
    input  logic                         flush,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    fetch_pkt_t       mem_q [DEPTH];
    fetch_pkt_t       head;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             trap_pending_q, trap_pending_d;
    logic             push, pop;

    assign in_ready  = (count_q != C_FULL) && !trap_pending_q && !flush;
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        trap_pending_d = trap_pending_q;
        if (flush) begin
            wr_ptr_d       = '0;
            rd_ptr_d       = '0;
            count_d        = '0;
            trap_pending_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
            // A queued trap always keeps trap_pending set, so clear and set never coincide.
            if (pop && head.trap_req.valid)      trap_pending_d = 1'b0;
            if (push && trap_req_f.valid)        trap_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            trap_pending_q <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            trap_pending_q <= trap_pending_d;
        end
    end

    // Storage needs no reset: entries are only observed when counted as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{pc: pc_f, pcplus4: pcplus4_f, inst: inst_f, trap_req: trap_req_f};
        end
    end

    always_comb begin
        pc_d       = '0;
        pcplus4_d  = '0;
        inst_d     = NOP_INST;
        trap_req_d = '0;
        if (out_valid) begin
            pc_d       = head.pc;
            pcplus4_d  = head.pcplus4;
            inst_d     = head.inst;
            trap_req_d = head.trap_req;
        end
    end

endmodule

`default_nettype wire
